// File: rtl/fir_stimuli_generator_param.sv
// FIR stimulus generator. Plays one pass of DEPTH signed samples from a
// writable table or from built-in impulse / step / ramp patterns. A pass is
// either one-shot (ending with a single-cycle done pulse) or repeated until
// stop is raised. The sample stream leaves through a valid/ready handshake.
//
// Handshake: result_valid is high for the whole of RUN. A sample moves
// downstream on every cycle where result_valid && result_ready are both
// high at the rising clock edge. While result_valid=1 and result_ready=0,
// result and result_valid hold their values. After a transfer, the next
// sample is presented on the following cycle, so throughput is one sample
// per cycle.
module fir_stimuli_generator_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RAMP_STEP  = 1
) (
  input  logic                  system1000,
  input  logic                  system1000_rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic                  loop,
  input  logic                  table_we,
  input  logic [ADDR_WIDTH-1:0] table_addr,
  input  logic [DATA_WIDTH-1:0] table_wdata,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_TABLE   = 2'd0;
  localparam logic [1:0] MODE_IMPULSE = 2'd1;
  localparam logic [1:0] MODE_STEP    = 2'd2;
  localparam logic [1:0] MODE_RAMP    = 2'd3;

  // Largest positive sample: 0111...1
  localparam logic [DATA_WIDTH-1:0] MAXP      = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] STEP_VAL  = DATA_WIDTH'(RAMP_STEP);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX   = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [1:0]            r_mode;
  logic                  r_loop;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_ramp;
  logic [DATA_WIDTH-1:0] r_table [DEPTH];
  logic [DATA_WIDTH-1:0] w_sample;
  logic                  w_run;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_launch;

  assign w_run    = (r_state == ST_RUN);
  assign w_launch = (r_state == ST_IDLE) && start;
  // valid equals "in RUN", so a transfer is RUN && ready
  assign w_xfer   = w_run && result_ready;
  assign w_last   = (r_index == LAST_IDX);

  // State register
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; stop wins over a simultaneous end-of-pass transfer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (w_xfer && w_last && !r_loop) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    busy         = w_run;
    result_valid = w_run;
    done         = (r_state == ST_DONE);
    result       = w_run ? w_sample : '0;
    dbg_state    = r_state;
  end

  // Run configuration, sample index and ramp accumulator
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_mode  <= MODE_TABLE;
      r_loop  <= 1'b0;
      r_index <= '0;
      r_ramp  <= '0;
    end else if (w_launch) begin
      r_mode  <= mode;
      r_loop  <= loop;
      r_index <= '0;
      r_ramp  <= '0;
    end else if (w_xfer && !stop) begin
      if (w_last) begin
        // wrap for the next pass; harmless when the run is ending
        r_index <= '0;
        r_ramp  <= '0;
      end else begin
        r_index <= r_index + ONE_IDX;
        r_ramp  <= r_ramp + STEP_VAL;
      end
    end
  end

  // Sample table; writable only while idle so a running pass is never disturbed
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if ((r_state == ST_IDLE) && table_we) begin
      r_table[table_addr] <= table_wdata;
    end
  end

  // Sample selection for the current index
  always_comb begin
    w_sample = '0;
    case (r_mode)
      MODE_TABLE:   w_sample = r_table[r_index];
      MODE_IMPULSE: w_sample = (r_index == '0) ? MAXP : '0;
      MODE_STEP:    w_sample = MAXP;
      MODE_RAMP:    w_sample = r_ramp;
      default:      w_sample = '0;
    endcase
  end

endmodule

// File: tb/tb_fir_stimuli_generator_param.sv
// Bench for fir_stimuli_generator_param: scoreboard-checked main instance
// (16-bit, 16 deep, ramp step 1) plus a small 8-bit, 4-deep, step-100
// instance for ramp wrap-around.
module tb_fir_stimuli_generator_param;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int STEP  = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, stop, loop, table_we, ready;
  logic [1:0]    mode;
  logic [AW-1:0] table_addr;
  logic [DW-1:0] table_wdata;
  logic [DW-1:0] result;
  logic          valid, busy, done;
  logic [1:0]    dbg_state;

  logic          s_start, s_stop, s_loop, s_we, s_ready;
  logic [1:0]    s_mode;
  logic [1:0]    s_addr;
  logic [7:0]    s_wdata;
  logic [7:0]    s_result;
  logic          s_valid, s_busy, s_done;
  logic [1:0]    s_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_tbl[DEPTH];
  int            ready_mode;   // 0 always, 1 toggle, 2 random
  logic          hold_pending;
  logic [DW-1:0] hold_val;

  // clock/reset block
  always #5 clk = ~clk;

  fir_stimuli_generator_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RAMP_STEP(STEP)
  ) u_dut (
    .system1000(clk), .system1000_rstn(rstn), .start(start), .stop(stop),
    .mode(mode), .loop(loop), .table_we(table_we), .table_addr(table_addr),
    .table_wdata(table_wdata), .result(result), .result_valid(valid),
    .result_ready(ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  fir_stimuli_generator_param #(
    .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .RAMP_STEP(100)
  ) u_dut_small (
    .system1000(clk), .system1000_rstn(rstn), .start(s_start), .stop(s_stop),
    .mode(s_mode), .loop(s_loop), .table_we(s_we), .table_addr(s_addr),
    .table_wdata(s_wdata), .result(s_result), .result_valid(s_valid),
    .result_ready(s_ready), .busy(s_busy), .done(s_done), .dbg_state(s_dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: sample k of a pass, straight from the pattern definitions
  function automatic logic [DW-1:0] model_sample(input int m, input int k);
    int maxp;
    maxp = (1 << (DW - 1)) - 1;
    case (m)
      0:       return model_tbl[k];
      1:       return (k == 0) ? DW'(maxp) : '0;
      2:       return DW'(maxp);
      default: return DW'(k * STEP);
    endcase
  endfunction

  function automatic int small_ramp(input int k);
    logic [7:0] t;
    t = 8'(k * 100);
    return int'($signed(t));
  endfunction

  // monitor: pop and compare on every transfer, check hold under backpressure
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rstn) begin
      if (hold_pending && valid) begin
        check("hold_stable", int'($signed(result)), int'($signed(hold_val)));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", int'($signed(result)), 0);
          if (int'($signed(result)) == 0) begin
            errors++;
            $display("FAIL unexpected_sample: actual=transfer required=none");
          end
        end else begin
          e = exp_q.pop_front();
          check("sample", int'($signed(result)), int'($signed(e)));
        end
      end
      hold_pending = valid && !ready;
      hold_val     = result;
    end else begin
      hold_pending = 1'b0;
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic write_entry(input int a, input logic [DW-1:0] d);
    table_we = 1'b1; table_addr = AW'(a); table_wdata = d;
    cycle();
    table_we = 1'b0;
    model_tbl[a] = d;
  endtask

  task automatic push_pass(input int m);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(model_sample(m, k));
  endtask

  task automatic start_run(input int m, input logic lp);
    mode = 2'(m); loop = lp; start = 1'b1;
    cycle();
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    loop = 1'($urandom_range(0, 1));
    check("busy_after_start", int'(busy), 1);
    check("valid_after_start", int'(valid), 1);
  endtask

  task automatic wait_done(input int exp_cycles);
    int   n = 0;
    logic prev_xfer = 1'b0;
    while (done !== 1'b1 && n < 400) begin
      prev_xfer = valid && ready;
      cycle();
      n++;
    end
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: actual=no done required=done within 400 cycles");
      return;
    end
    check("done_after_last_xfer", int'(prev_xfer), 1);
    check("queue_drained_at_done", exp_q.size(), 0);
    check("busy_at_done", int'(busy), 0);
    check("valid_at_done", int'(valid), 0);
    if (exp_cycles > 0) check("run_cycles", n, exp_cycles);
    cycle();
    check("done_one_cycle", int'(done), 0);
  endtask

  task automatic stop_when_last();
    int n = 0;
    int saw_done = 0;
    while (exp_q.size() > 1 && n < 400) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL stop_timeout: actual=%0d left required=1", exp_q.size());
      exp_q.delete();
      return;
    end
    stop = 1'b1; ready = 1'b1;
    cycle();
    stop = 1'b0;
    check("stop_valid_drop", int'(valid), 0);
    check("stop_busy_drop", int'(busy), 0);
    check("stop_last_accepted", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (done) saw_done++;
      cycle();
    end
    check("stop_no_done", saw_done, 0);
  endtask

  task automatic run_small();
    int k = 0;
    int n = 0;
    s_mode = 2'd3; s_loop = 1'b0; s_ready = 1'b1; s_start = 1'b1;
    cycle();
    s_start = 1'b0;
    while (s_done !== 1'b1 && n < 50) begin
      if (s_valid && s_ready) begin
        check("small_ramp", int'($signed(s_result)), small_ramp(k));
        k++;
      end
      cycle();
      n++;
    end
    check("small_sample_count", k, 4);
    check("small_done", int'(s_done), 1);
    check("small_busy_at_done", int'(s_busy), 0);
  endtask

  // stimulus sequence and final report
  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; mode = 2'd0;
    table_we = 1'b0; table_addr = '0; table_wdata = '0; ready = 1'b1;
    s_start = 1'b0; s_stop = 1'b0; s_loop = 1'b0; s_we = 1'b0; s_mode = 2'd0;
    s_addr = '0; s_wdata = '0; s_ready = 1'b1;
    ready_mode = 0; hold_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", int'(result), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rstn = 1'b1;
    cycle();
    check("post_reset_valid", int'(valid), 0);
    check("post_reset_result", int'(result), 0);

    // table cleared by reset: 16 zeros
    push_pass(0); start_run(0, 1'b0); wait_done(DEPTH);

    // table one-shot with full throughput
    for (int i = 0; i < DEPTH; i++) write_entry(i, DW'(i * 100 - 800));
    push_pass(0); start_run(0, 1'b0); wait_done(DEPTH);

    // impulse at full rate, step under random backpressure
    push_pass(1); start_run(1, 1'b0); wait_done(DEPTH);
    ready_mode = 2;
    push_pass(2); start_run(2, 1'b0); wait_done(0);

    // looped ramp with toggling ready, stopped mid second pass
    ready_mode = 1;
    push_pass(3); push_pass(3);
    for (int i = 0; i < 12; i++) void'(exp_q.pop_back());
    start_run(3, 1'b1); stop_when_last();

    // write lockout and start-while-busy during a random-ready table run
    ready_mode = 2;
    push_pass(0); start_run(0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    table_we = 1'b1; table_addr = 4'd3; table_wdata = DW'($urandom_range(1, 999));
    start = 1'b1; mode = 2'd2;
    cycle();
    table_we = 1'b0; start = 1'b0;
    wait_done(0);
    ready_mode = 0;
    push_pass(0); start_run(0, 1'b0); wait_done(DEPTH);

    // stop during a random-ready table run
    ready_mode = 2;
    push_pass(0);
    for (int i = 0; i < 6; i++) void'(exp_q.pop_back());
    start_run(0, 1'b0); stop_when_last();

    // reset mid-run clears everything including the table
    ready_mode = 0;
    push_pass(0); start_run(0, 1'b1);
    for (int i = 0; i < 4; i++) cycle();
    rstn = 1'b0;
    #1;
    check("async_reset_valid", int'(valid), 0);
    check("async_reset_busy", int'(busy), 0);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = '0;
    cycle();
    rstn = 1'b1;
    cycle();
    push_pass(0); start_run(0, 1'b0); wait_done(DEPTH);

    // ramp wrap on the narrow instance
    run_small();

    repeat (2) cycle();
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
